mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single physical memory port between two requesters: instruction fetch (I-side, read-only) and data load/store (D-side, read/write).
- Sits between the pipelined CPU's fetch and memory stages and the existing cache/memory interface.
- Uses the same request/response protocol as the CPU memory port: a requester holds its request level until the cycle it sees resp.
- Arbitration favours the D-side, with a bounded-streak fairness rule so the I-side cannot starve.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced to win (range 1..15)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
i_read  input  1  I-side read request, held until i_resp
i_address  input  32  I-side address
i_rdata  output  32  I-side read data, valid when i_resp=1
i_resp  output  1  I-side completion, one cycle
d_read  input  1  D-side read request, held until d_resp
d_write  input  1  D-side write request, held until d_resp
d_byte_enable  input  4  D-side write byte mask
d_address  input  32  D-side address
d_wdata  input  32  D-side write data
d_rdata  output  32  D-side read data, valid when d_resp=1
d_resp  output  1  D-side completion, one cycle
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_byte_enable  output  4  memory byte mask
mem_address  output  32  memory address
mem_wdata  output  32  memory write data
mem_resp  input  1  memory completion
mem_rdata  input  32  memory read data

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Registered state plus a streak counter, 4 bits, saturating at MAX_D_STREAK.
- Reset (async, any cycle, including mid-transfer):
  - state=IDLE, streak=0.
  - All mem_* outputs 0; i_resp=d_resp=0.
  - Any in-flight memory response is ignored after reset.
- IDLE:
  - mem_* outputs driven 0; no resp asserted.
  - Request sampling: d_req = d_read|d_write; i_req = i_read.
  - Only d_req: go to SERVE_D.
  - Only i_req: go to SERVE_I.
  - Both: go to SERVE_I if streak==MAX_D_STREAK, else SERVE_D.
  - Neither: stay in IDLE.
- SERVE_I:
  - mem_read = i_read; mem_write = 0; mem_address = i_address; mem_byte_enable = 4'b1111; mem_wdata = 0.
  - i_resp = mem_resp combinationally.
- SERVE_D:
  - mem_read = d_read & ~d_write; mem_write = d_write.
  - mem_address, mem_byte_enable and mem_wdata come from the D-side inputs.
  - d_resp = mem_resp combinationally.
- i_rdata and d_rdata always equal mem_rdata; consumers qualify them with their resp.
- Exit from SERVE_x: on mem_resp=1 go to IDLE next cycle. There is always exactly one IDLE bubble between grants; no direct handoff.
- Streak update, performed when leaving IDLE:
  - Grant D with i_req=1: streak+1, saturating.
  - Grant I: streak cleared to 0.
  - Grant D with i_req=0: streak cleared to 0.
- Latency: request rising in cycle N while IDLE gives the strobe in N+1. Resp appears in the same cycle as mem_resp, and the next grant can strobe no earlier than 2 cycles after resp.
- The grant is held until mem_resp even if the granted requester drops its request. The strobe follows the live request, so a dropped request deasserts the strobe, but the state still waits for mem_resp.
- d_read and d_write both high is a protocol violation; the write wins and mem_read=0.
- The non-granted requester never sees resp, regardless of mem_resp.
- mem_resp in IDLE is ignored; no resp is asserted.

Test Plan:
- I-only: i_read=1, i_address=0x60, memory responds 3 cycles after strobe with 0xDEADBEEF -> mem_read high from cycle 1 with mem_address=0x60; i_resp=1 with i_rdata=0xDEADBEEF; d_resp stays 0; IDLE next cycle.
- Simultaneous: i_read and d_write (addr 0x100, wdata 0x12345678, byte_enable 0011) both in cycle 0 -> D is served first (mem_write=1, mask 0011); after its resp plus one IDLE cycle, I is served.
- Fairness, MAX_D_STREAK=4: I held continuously while D issues back-to-back reads -> exactly 4 D grants, then the I grant, then the streak resets and D wins again.
- Async reset: rst pulsed mid SERVE_D before mem_resp -> all mem_* outputs 0 immediately (same cycle, no clock edge needed); state IDLE; a late mem_resp produces no d_resp.
- Read/write conflict: d_read=d_write=1 -> mem_write=1, mem_read=0.
- Spurious mem_resp in IDLE -> no resp asserted.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles the three request/response channels that meet at the memory port
// arbiter:
//   I-side : i_read, i_address            -> i_rdata, i_resp
//   D-side : d_read, d_write, d_byte_enable, d_address, d_wdata
//                                         -> d_rdata, d_resp
//   Memory : mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
//                                         <- mem_resp, mem_rdata
//
// Modports:
//   slave  - the arbiter's view: takes requester requests and memory
//            completions, drives requester responses and the memory strobes.
//   master - the environment's view (CPU stages plus memory): the mirror
//            image of slave.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

  // I-side (instruction fetch, read-only)
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;

  // D-side (data load/store)
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;

  // Shared physical memory port
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_byte_enable, d_address, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_byte_enable, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one physical memory port between the instruction-fetch requester
// (I-side, read-only) and the data load/store requester (D-side, read/write).
// Both requesters hold their request level until they see their resp pulse.
//
// Arbitration favours the D-side. A saturating streak counter tracks how many
// consecutive D grants were given while the I-side was also waiting; once it
// reaches MAX_D_STREAK the I-side wins the next contested arbitration.
//
// Every grant is followed by exactly one IDLE cycle, so a new strobe can
// appear no earlier than two cycles after the previous resp.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_port_arbiter_if.slave: I-side, D-side and memory channels
//
// Parameters:
//   MAX_D_STREAK - contested D grants allowed before I is forced to win (1..15)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;

  logic        i_req;
  logic        d_req;
  logic        streak_full;
  logic [3:0]  streak_inc;

  // Combinational outputs before they are placed on the interface.
  logic        mem_read_c;
  logic        mem_write_c;
  logic [3:0]  mem_byte_enable_c;
  logic [31:0] mem_address_c;
  logic [31:0] mem_wdata_c;
  logic        i_resp_c;
  logic        d_resp_c;

  assign i_req       = bus.i_read;
  assign d_req       = bus.d_read | bus.d_write;
  assign streak_full = (streak_q == STREAK_MAX);
  assign streak_inc  = streak_full ? streak_q : streak_q + 4'd1;

  // ---------------------------------------------------------------------------
  // State and streak registers. Reset returns to IDLE, which by construction
  // drives every memory strobe low, so an in-flight mem_resp that lands after
  // reset finds nothing to complete.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; without it a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d           = state_q;
    streak_d          = streak_q;
    mem_read_c        = 1'b0;
    mem_write_c       = 1'b0;
    mem_byte_enable_c = 4'b0000;
    mem_address_c     = 32'd0;
    mem_wdata_c       = 32'd0;
    i_resp_c          = 1'b0;
    d_resp_c          = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Memory port is quiet here; any stray mem_resp is simply dropped.
        if (d_req && !(i_req && streak_full)) begin
          state_d  = SERVE_D;
          // Only a contested D win lengthens the streak.
          streak_d = i_req ? streak_inc : 4'd0;
        end else if (i_req) begin
          state_d  = SERVE_I;
          streak_d = 4'd0;
        end
      end

      SERVE_I: begin
        // Strobe follows the live request; the grant itself is held until
        // mem_resp even if the fetch is withdrawn.
        mem_read_c        = bus.i_read;
        mem_address_c     = bus.i_address;
        mem_byte_enable_c = 4'b1111;
        i_resp_c          = bus.mem_resp;
        if (bus.mem_resp) begin
          state_d = IDLE;
        end
      end

      SERVE_D: begin
        // A simultaneous read+write is illegal; the write takes priority.
        mem_read_c        = bus.d_read & ~bus.d_write;
        mem_write_c       = bus.d_write;
        mem_address_c     = bus.d_address;
        mem_byte_enable_c = bus.d_byte_enable;
        mem_wdata_c       = bus.d_wdata;
        d_resp_c          = bus.mem_resp;
        if (bus.mem_resp) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Interface drive. Read data is a straight wire to both sides; each
  // consumer qualifies it with its own resp.
  // ---------------------------------------------------------------------------
  assign bus.mem_read        = mem_read_c;
  assign bus.mem_write       = mem_write_c;
  assign bus.mem_byte_enable = mem_byte_enable_c;
  assign bus.mem_address     = mem_address_c;
  assign bus.mem_wdata       = mem_wdata_c;
  assign bus.i_resp          = i_resp_c;
  assign bus.d_resp          = d_resp_c;
  assign bus.i_rdata         = bus.mem_rdata;
  assign bus.d_rdata         = bus.mem_rdata;

endmodule : mem_port_arbiter
